// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (core MEM stage and ext loader)
// and the single-port data memory. The arbiter takes the slave view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  logic              ext_req;
  logic              ext_we;
  logic              ext_lock;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_a, mem_wd, mem_we,
    input  mem_rd
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_a, mem_wd, mem_we,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has priority, ext is guaranteed progress by a starvation
// counter and a bounded lock (burst) FSM with a one-cycle cool-down back to the core.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_LOCK = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic              ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              force_win;
  logic              ext_gnt;
  logic              core_stall;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;

  assign force_win = (starve_cnt_q == SW'(STARVE_LIMIT));

  // Grant / stall decision; gated off combinationally while reset is asserted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ext_gnt    = 1'b0;
    core_stall = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        ext_gnt    = bus.ext_req & (~bus.core_req | force_win);
        core_stall = bus.core_req & ext_gnt;
      end
      ST_LOCK: begin
        ext_gnt    = bus.ext_req;
        core_stall = bus.core_req;
      end
      default: begin
        ext_gnt    = 1'b0;
        core_stall = 1'b0;
      end
    endcase
    if (!reset_n) begin
      ext_gnt    = 1'b0;
      core_stall = 1'b0;
    end
  end

  // Memory port mux: a stalled core or an ungranted ext never writes.
  always_comb begin
    if (ext_gnt) begin
      mem_a  = bus.ext_addr;
      mem_wd = bus.ext_wdata;
      mem_we = bus.ext_we;
    end else begin
      mem_a  = bus.core_addr;
      mem_wd = bus.core_wdata;
      mem_we = bus.core_we & bus.core_req & ~core_stall;
    end
    if (!reset_n) mem_we = 1'b0;
  end

  // Next-state logic for the FSM, counters and ext read return.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    starve_cnt_d = starve_cnt_q;
    ext_rvalid_d = 1'b0;
    ext_rdata_d  = ext_rdata_q;

    unique case (state_q)
      ST_ARB: begin
        if (ext_gnt && bus.ext_lock) begin
          state_d    = ST_LOCK;
          lock_cnt_d = LW'(1);
        end
      end
      ST_LOCK: begin
        if (!bus.ext_lock || lock_cnt_q == LW'(MAX_LOCK)) begin
          state_d    = ST_COOL;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase

    if (ext_gnt || !bus.ext_req) begin
      starve_cnt_d = '0;
    end else if (!force_win) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    if (ext_gnt && !bus.ext_we) begin
      ext_rvalid_d = 1'b1;
      ext_rdata_d  = bus.mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      state_q      <= ST_ARB;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      // NOTE: the read-data register is reset too, so a dropped read never leaks stale data.
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign bus.core_rdata = bus.mem_rd;
  assign bus.core_stall = core_stall;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.mem_a      = mem_a;
  assign bus.mem_wd     = mem_wd;
  assign bus.mem_we     = mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: default instance plus a MAX_LOCK=1 instance,
// with a small synchronous-write / async-read memory model behind the default one.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .MAX_LOCK(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .MAX_LOCK(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  logic [31:0] mem [256];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;
  assign bus.mem_rd  = mem[bus.mem_a[7:0]];
  assign bus1.mem_rd = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                       input logic [31:0] c_wd, input logic e_req, input logic e_we,
                       input logic e_lock, input logic [31:0] e_addr, input logic [31:0] e_wd);
    bus.core_req   = c_req;
    bus.core_we    = c_we;
    bus.core_addr  = c_addr;
    bus.core_wdata = c_wd;
    bus.ext_req    = e_req;
    bus.ext_we     = e_we;
    bus.ext_lock   = e_lock;
    bus.ext_addr   = e_addr;
    bus.ext_wdata  = e_wd;
  endtask

  task automatic drive1(input logic c_req, input logic e_req, input logic e_lock);
    bus1.core_req   = c_req;
    bus1.core_we    = 1'b0;
    bus1.core_addr  = 32'h4;
    bus1.core_wdata = 32'h0;
    bus1.ext_req    = e_req;
    bus1.ext_we     = 1'b0;
    bus1.ext_lock   = e_lock;
    bus1.ext_addr   = 32'h8;
    bus1.ext_wdata  = 32'h0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset with both requesters active: all outputs gated off.
    reset_n = 1'b0;
    drive(1, 1, 32'h10, 32'h11, 1, 1, 1, 32'h20, 32'h22);
    drive1(0, 0, 0);
    next_cycle(); #2;
    check("rst_ext_gnt", bus.ext_gnt, 0);
    check("rst_core_stall", bus.core_stall, 0);
    check("rst_mem_we", bus.mem_we, 0);
    next_cycle(); #2;
    check("rst_rvalid", bus.ext_rvalid, 0);
    check("rst_rdata", bus.ext_rdata, 0);
    next_cycle();
    reset_n = 1'b1;

    // Core-only store, second store, then a load.
    drive(1, 1, 32'h10, 32'hDEAD, 0, 0, 0, 32'h0, 32'h0); #2;
    check("c1_mem_we", bus.mem_we, 1);
    check("c1_mem_a", bus.mem_a, 32'h10);
    check("c1_mem_wd", bus.mem_wd, 32'hDEAD);
    check("c1_stall", bus.core_stall, 0);
    check("c1_gnt", bus.ext_gnt, 0);
    next_cycle();
    drive(1, 1, 32'h20, 32'h1234, 0, 0, 0, 32'h0, 32'h0); #2;
    check("c2_mem_we", bus.mem_we, 1);
    next_cycle();
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0); #2;
    check("c3_rdata", bus.core_rdata, 32'hDEAD);
    check("c3_mem_we", bus.mem_we, 0);

    // Ext-only read: same-cycle grant, rvalid the following cycle only.
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0); #2;
    check("e1_gnt", bus.ext_gnt, 1);
    check("e1_mem_a", bus.mem_a, 32'h20);
    check("e1_mem_we", bus.mem_we, 0);
    check("e1_rvalid_pre", bus.ext_rvalid, 0);
    next_cycle();
    idle(); #2;
    check("e2_rvalid", bus.ext_rvalid, 1);
    check("e2_rdata", bus.ext_rdata, 32'h1234);
    next_cycle(); #2;
    check("e3_rvalid", bus.ext_rvalid, 0);
    check("e3_rdata_hold", bus.ext_rdata, 32'h1234);

    // Ext write gives no rvalid; read back of the written word.
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h30, 32'hBEEF); #2;
    check("w1_gnt", bus.ext_gnt, 1);
    check("w1_mem_we", bus.mem_we, 1);
    check("w1_mem_wd", bus.mem_wd, 32'hBEEF);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h30, 32'h0); #2;
    check("w2_rvalid", bus.ext_rvalid, 0);
    next_cycle();
    idle(); #2;
    check("w3_rvalid", bus.ext_rvalid, 1);
    check("w3_rdata", bus.ext_rdata, 32'hBEEF);

    // Starvation: core wins four cycles, ext forced on the fifth.
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1, 1, 32'h40, 32'h5555, 1, 0, 0, 32'h10, 32'h0); #2;
      check($sformatf("sv%0d_gnt", i), bus.ext_gnt, (i == 4) ? 1 : 0);
      check($sformatf("sv%0d_stall", i), bus.core_stall, (i == 4) ? 1 : 0);
      check($sformatf("sv%0d_mem_a", i), bus.mem_a, (i == 4) ? 32'h10 : 32'h40);
      check($sformatf("sv%0d_mem_we", i), bus.mem_we, (i == 4) ? 0 : 1);
    end
    next_cycle();
    drive(1, 1, 32'h40, 32'h5555, 1, 0, 0, 32'h10, 32'h0); #2;
    check("sv5_gnt_cleared", bus.ext_gnt, 0);
    check("sv5_rvalid", bus.ext_rvalid, 1);
    check("sv5_rdata", bus.ext_rdata, 32'hDEAD);
    next_cycle();
    idle(); #2;
    check("sv6_rvalid", bus.ext_rvalid, 0);

    // Lock burst: forced grant in ARB, eight LOCK cycles, one COOL, back to ARB.
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1, 0, 32'h10, 32'h0, 1, 1, 1, 32'h50 + i, 32'h0); #2;
      check($sformatf("lk_arb%0d_gnt", i), bus.ext_gnt, (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive(1, 0, 32'h10, 32'h0, 1, 1, 1, 32'h58, 32'h0); #2;
      check($sformatf("lk%0d_gnt", i), bus.ext_gnt, 1);
      check($sformatf("lk%0d_stall", i), bus.core_stall, 1);
    end
    next_cycle();
    drive(1, 0, 32'h10, 32'h0, 1, 1, 1, 32'h58, 32'h0); #2;
    check("cool_gnt", bus.ext_gnt, 0);
    check("cool_stall", bus.core_stall, 0);
    check("cool_mem_a", bus.mem_a, 32'h10);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0); #2;
    check("post_cool_arb_gnt", bus.ext_gnt, 1);
    next_cycle();
    idle(); #2;
    check("post_cool_rdata", bus.ext_rdata, 32'h1234);

    // Early unlock, including an ext-idle LOCK cycle that still stalls the core.
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h60, 32'h6); #2;
    check("eu_arb_gnt", bus.ext_gnt, 1);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h60, 32'h6); #2;
    check("eu_l1_gnt", bus.ext_gnt, 1);
    next_cycle();
    drive(1, 1, 32'h70, 32'h7, 0, 1, 1, 32'h60, 32'h6); #2;
    check("eu_l2_gnt", bus.ext_gnt, 0);
    check("eu_l2_stall", bus.core_stall, 1);
    check("eu_l2_mem_we", bus.mem_we, 0);
    next_cycle();
    drive(1, 1, 32'h70, 32'h7, 1, 1, 0, 32'h61, 32'h61); #2;
    check("eu_l3_gnt", bus.ext_gnt, 1);
    check("eu_l3_mem_a", bus.mem_a, 32'h61);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h62, 32'h62); #2;
    check("eu_cool_gnt", bus.ext_gnt, 0);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h62, 32'h62); #2;
    check("eu_arb_gnt2", bus.ext_gnt, 1);
    next_cycle();
    drive(1, 1, 32'h74, 32'h74, 0, 0, 0, 32'h0, 32'h0); #2;
    check("eu_arb_stall", bus.core_stall, 0);
    check("eu_arb_mem_we", bus.mem_we, 1);

    // Reset while in LOCK with a read just returned.
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h20, 32'h0); #2;
    check("rl_arb_gnt", bus.ext_gnt, 1);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h20, 32'h0); #2;
    check("rl_l1_gnt", bus.ext_gnt, 1);
    next_cycle();
    reset_n = 1'b0;
    drive(1, 1, 32'h80, 32'h8, 1, 1, 1, 32'h84, 32'h9); #2;
    check("rl_rst_mem_we", bus.mem_we, 0);
    check("rl_rst_gnt", bus.ext_gnt, 0);
    check("rl_rst_stall", bus.core_stall, 0);
    check("rl_rst_rvalid_pend", bus.ext_rvalid, 1);
    next_cycle();
    reset_n = 1'b1;
    drive(1, 1, 32'h88, 32'h99, 0, 0, 0, 32'h0, 32'h0); #2;
    check("rl_post_rvalid", bus.ext_rvalid, 0);
    check("rl_post_rdata", bus.ext_rdata, 0);
    check("rl_post_stall", bus.core_stall, 0);
    check("rl_post_mem_we", bus.mem_we, 1);

    // MAX_LOCK=1 instance: single LOCK cycle then COOL.
    next_cycle();
    idle();
    drive1(0, 1, 1); #2;
    check("ml1_arb_gnt", bus1.ext_gnt, 1);
    next_cycle(); #2;
    check("ml1_lock_gnt", bus1.ext_gnt, 1);
    next_cycle(); #2;
    check("ml1_cool_gnt", bus1.ext_gnt, 0);
    next_cycle();
    drive1(0, 1, 0); #2;
    check("ml1_arb2_gnt", bus1.ext_gnt, 1);
    next_cycle();
    drive1(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
